run_limit_serializer: RTL and testbench
=======================================

Name: run_limit_serializer

Overview:
- Transmit-side partner of the serial run detector: takes parallel words on a valid/ready handshake and shifts them out MSB-first on serial line w.
- Whenever RUN_MAX identical consecutive bits have been emitted, it inserts one complementary stuff bit, so the line never carries a run longer than RUN_MAX.
- Drives the detector's w input.
- With the default RUN_MAX=3, a downstream 4-consecutive-bit detector never asserts z while w_valid=1.

Parameters:
- DATA_W, 8: width of the parallel input word.
- RUN_MAX, 3: maximum number of identical consecutive bits on w; must be at least 2.

Ports:
- clock, input, 1: rising-edge clock.
- rst, input, 1: reset, asynchronous, active-high.
- din, input, DATA_W: parallel word to transmit.
- din_valid, input, 1: din holds a word.
- din_ready, output, 1: the block accepts din this cycle.
- w, output, 1: serial bit (data or stuff).
- w_valid, output, 1: w carries a bit this cycle.
- w_stuff, output, 1: the current w bit is a stuff bit, to be discarded by the receiver.
- busy, output, 1: the state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate): w=0, w_valid=0, w_stuff=0, busy=0, state=IDLE, run_cnt=0, last_bit=0, bit_idx=0. A word in flight is dropped. din_ready=1 after release.
- States:
  - IDLE: w_valid=0. din_ready=1.
  - SHIFT: w_valid=1 and w=shreg[MSB] (data bit).
  - STUFF: w_valid=1, w=~last_bit, w_stuff=1.
- Outputs are registered except din_ready, which is combinational from registered state only, never from din_valid.
- Accept when din_valid && din_ready at a rising edge. Latency is 1: the next cycle is SHIFT with w=din[DATA_W-1]. din is captured into the shift register at acceptance.
- Run tracking, updated each cycle w_valid=1:
  - If w==last_bit and run_cnt>0: run_cnt+1.
  - Otherwise: run_cnt=1.
  - last_bit=w.
  - Stuff bits count in the run: after a stuff bit, run_cnt=1.
- stuff_req = (post-update run_cnt == RUN_MAX). After any emitted bit with stuff_req, the next state is STUFF regardless of remaining data.
- SHIFT transitions:
  - stuff_req: go to STUFF.
  - Else if bits remain: stay in SHIFT, shift left, bit_idx+1.
  - Else (last data bit): if an accept happens this cycle, go to SHIFT with the new word; otherwise go to IDLE.
- STUFF transitions:
  - Data bits remain: go to SHIFT.
  - Data exhausted: if an accept happens, go to SHIFT with the new word; otherwise go to IDLE.
- din_ready is high in:
  - IDLE.
  - SHIFT on the last data bit when stuff_req=0.
  - STUFF when all data bits have been sent.
- Back-to-back words therefore have no idle gap.
- Run state persists across back-to-back words. Entering IDLE clears run_cnt to 0 and last_bit to 0.
- din_valid while din_ready=0 is ignored; the source holds din.
- Width rules:
  - run_cnt width is RUN_W = clog2(RUN_MAX+1); run_cnt never exceeds RUN_MAX.
  - bit_idx width is clog2(DATA_W).
- Bits per word: DATA_W plus the number of stuffs, at most DATA_W + DATA_W/RUN_MAX + 1.

Decomposition:
- Package run_limit_pkg holds:
  - State typedef with encodings IDLE=2'b00, SHIFT=2'b01, STUFF=2'b10.
  - Function clog2.
  - Constants DEF_DATA_W=8 and DEF_RUN_MAX=3.
- Sub-module run_tracker holds run_cnt and last_bit.
  - Inputs: clock, rst, clear, bit_valid, bit.
  - Output: stuff_req.
  - Instantiated once. Shared later with the receive-side destuffer.

Test Plan:
- Word without stuffing: din=8'hA5, single accept from IDLE. Required: w = 1,0,1,0,0,1,0,1 over 8 cycles, w_stuff never 1, w_valid=1 starting the cycle after acceptance, then IDLE and busy=0.
- All ones: din=8'hFF. Required: w = 1,1,1,0*,1,1,1,0*,1,1 (10 cycles, * marks w_stuff=1). No trailing stuff, since the final run_cnt is 2.
- Word ending in a stuff bit: din=8'h1F. Required:
  - w = 0,0,0,1*,1,1,0*,1,1,1,0* (11 cycles).
  - din_ready=1 during the final stuff cycle, not during the last data bit.
- Back-to-back: din=8'h00 then 8'hFF, din_valid held high. Required:
  - First word: w = 0,0,0,1*,0,0,0,1*,0,0.
  - Second word follows with no gap: 1,1,1,0*,1,1,1,0*,1,1.
  - Exactly 2 handshakes. A 4-run detector on w stays z=0 throughout.
- Asynchronous reset mid-word: rst pulsed between edges during bit 5 of 8'hF0. Required:
  - w_valid=0, w=0 and busy=0 immediately, without waiting for an edge.
  - After release: din_ready=1. A new 8'hA5 is sent exactly as in the first scenario, with no residual run state.
- Backpressure: din_valid asserted during mid-word SHIFT. Required: din_ready=0 and no acceptance until the last-bit or final-stuff cycle; then the new word's MSB appears the next cycle.

Source files
------------

// File: rtl/run_limit_serializer_pkg.sv
// Shared types and constants for the run-limited serial transmit path.
// Also used by the receive-side destuffer, so keep it free of block-specific logic.
package run_limit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        STUFF = 2'b10
    } state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_RUN_MAX = 3;

    // Ceiling log2; clog2(1) is 0, so callers needing a 1-bit minimum must clamp.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/run_limit_serializer_run_tracker.sv
// Tracks the length of the current run of identical bits on a serial line and
// flags when the bit just seen completes a run of RUN_MAX.
module run_tracker
    import run_limit_pkg::*;
#(
    parameter int RUN_MAX = DEF_RUN_MAX
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic bit_valid,
    input  logic bit_i,
    output logic stuff_req
);

    localparam int              RUN_W     = clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(RUN_MAX);

    logic [RUN_W-1:0] run_cnt_q;
    logic [RUN_W-1:0] run_cnt_d;
    logic             last_bit_q;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (bit_valid) begin
            if (bit_i != last_bit_q || run_cnt_q == '0) begin
                run_cnt_d = RUN_W'(1);
            end else if (run_cnt_q != RUN_LIMIT) begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
            end
        end
    end

    // Decision is on the post-update count so the stuff bit follows immediately.
    assign stuff_req = bit_valid && (run_cnt_d == RUN_LIMIT);

    // NOTE: state registers use non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            run_cnt_q  <= '0;
            last_bit_q <= 1'b0;
        end else if (clear) begin
            run_cnt_q  <= '0;
            last_bit_q <= 1'b0;
        end else if (bit_valid) begin
            run_cnt_q  <= run_cnt_d;
            last_bit_q <= bit_i;
        end
    end

endmodule

// File: rtl/run_limit_serializer.sv
// Parallel-to-serial transmitter, MSB first, inserting a complementary stuff bit
// after every RUN_MAX identical bits so the line never carries a longer run.
module run_limit_serializer
    import run_limit_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RUN_MAX = DEF_RUN_MAX
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              w,
    output logic              w_valid,
    output logic              w_stuff,
    output logic              busy
);

    localparam int               IDX_W    = (clog2(DATA_W) > 0) ? clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [IDX_W-1:0]  bit_idx_d;
    logic              w_q;
    logic              w_d;
    logic              w_valid_q;
    logic              w_valid_d;
    logic              w_stuff_q;
    logic              w_stuff_d;
    logic              busy_q;
    logic              busy_d;

    logic              last_data;
    logic              stuff_req;
    logic              accept;
    logic              track_clear;

    // bit_idx is the index of the data bit most recently placed on w; it is
    // not advanced across a stuff bit, so in STUFF it still names that bit.
    assign last_data = (bit_idx_q == LAST_IDX);

    always_comb begin
        din_ready = 1'b0;
        case (state_q)
            IDLE:    din_ready = 1'b1;
            SHIFT:   din_ready = last_data && !stuff_req;
            STUFF:   din_ready = last_data;
            default: din_ready = 1'b0;
        endcase
    end

    assign accept = din_valid && din_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    shreg_d   = din;
                    bit_idx_d = '0;
                end
            end
            SHIFT: begin
                if (stuff_req) begin
                    state_d = STUFF;
                end else if (!last_data) begin
                    shreg_d   = shreg_q << 1;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end else if (accept) begin
                    shreg_d   = din;
                    bit_idx_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            STUFF: begin
                if (!last_data) begin
                    state_d   = SHIFT;
                    shreg_d   = shreg_q << 1;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end else if (accept) begin
                    state_d   = SHIFT;
                    shreg_d   = din;
                    bit_idx_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_idx_d = '0;
            end
        endcase
    end

    // The stuff bit complements the data bit currently on the line.
    always_comb begin
        w_valid_d = (state_d != IDLE);
        w_stuff_d = (state_d == STUFF);
        busy_d    = (state_d != IDLE);
        w_d       = 1'b0;
        if (state_d == SHIFT) begin
            w_d = shreg_d[DATA_W-1];
        end else if (state_d == STUFF) begin
            w_d = ~w_q;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            w_stuff_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            w_stuff_q <= w_stuff_d;
            busy_q    <= busy_d;
        end
    end

    // NOTE: the shift register is pure datapath, only read in SHIFT after a load, so it carries no reset.
    always_ff @(posedge clock) begin
        shreg_q <= shreg_d;
    end

    assign track_clear = (state_d == IDLE);

    run_tracker #(
        .RUN_MAX (RUN_MAX)
    ) u_run_tracker (
        .clock     (clock),
        .rst       (rst),
        .clear     (track_clear),
        .bit_valid (w_valid_q),
        .bit_i     (w_q),
        .stuff_req (stuff_req)
    );

    assign w       = w_q;
    assign w_valid = w_valid_q;
    assign w_stuff = w_stuff_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_run_limit_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based model of the stuffed bitstream.
module tb_run_limit_serializer;

    localparam int DATA_W  = 8;
    localparam int RUN_MAX = 3;

    typedef struct packed {
        logic b;
        logic s;
    } ent_t;

    logic              clock;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              w;
    logic              w_valid;
    logic              w_stuff;
    logic              busy;

    int          total;
    int          bad;
    ent_t        exp_q[$];
    int          m_run;
    logic        m_last;
    int          obs_run;
    logic        obs_last;
    bit          acc_flag;
    int          hs_cnt;
    logic [63:0] cap_bits;
    logic [63:0] cap_stuff;
    int          cap_n;
    int          waited;

    run_limit_serializer #(
        .DATA_W  (DATA_W),
        .RUN_MAX (RUN_MAX)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .w         (w),
        .w_valid   (w_valid),
        .w_stuff   (w_stuff),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: emit a bit, track the run, append a complement when it hits RUN_MAX.
    task automatic model_push(input logic b, input logic s);
        ent_t e;
        e.b = b;
        e.s = s;
        exp_q.push_back(e);
        if (b == m_last && m_run > 0) m_run = m_run + 1;
        else m_run = 1;
        m_last = b;
    endtask

    task automatic gen_stream(input logic [DATA_W-1:0] d);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            model_push(d[i], 1'b0);
            if (m_run == RUN_MAX) model_push(~d[i], 1'b1);
        end
    endtask

    task automatic cap_clear();
        cap_bits  = '0;
        cap_stuff = '0;
        cap_n     = 0;
    endtask

    // One clock: sample at negedge, compare against the model, advance it, resync after posedge.
    task automatic step();
        bit   was_idle;
        bit   exp_rdy;
        ent_t e;
        @(negedge clock);
        was_idle = (exp_q.size() == 0);
        exp_rdy  = (exp_q.size() <= 1);
        check("w_valid", 64'(w_valid), 64'(!was_idle));
        check("din_ready", 64'(din_ready), 64'(exp_rdy));
        check("busy", 64'(busy), 64'(!was_idle));
        if (!was_idle) begin
            e = exp_q.pop_front();
            check("w_bit", 64'(w), 64'(e.b));
            check("w_stuff", 64'(w_stuff), 64'(e.s));
            cap_bits  = {cap_bits[62:0], w};
            cap_stuff = {cap_stuff[62:0], w_stuff};
            cap_n     = cap_n + 1;
            if (w == obs_last && obs_run > 0) obs_run = obs_run + 1;
            else obs_run = 1;
            obs_last = w;
            check("line_run_ok", 64'(obs_run <= RUN_MAX), 64'd1);
        end else begin
            obs_run = 0;
        end
        if (din_valid && din_ready) hs_cnt = hs_cnt + 1;
        acc_flag = din_valid && exp_rdy;
        if (acc_flag) begin
            if (was_idle) begin
                m_run  = 0;
                m_last = 1'b0;
            end
            gen_stream(din);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit hold, output int n);
        din       = d;
        din_valid = 1'b1;
        n         = 0;
        acc_flag  = 1'b0;
        while (!acc_flag && n < 64) begin
            step();
            n = n + 1;
        end
        check("accept_timeout", 64'(acc_flag), 64'd1);
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n = n + 1;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m_run     = 0;
        m_last    = 1'b0;
        obs_run   = 0;
        obs_last  = 1'b0;
        hs_cnt    = 0;
        acc_flag  = 1'b0;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        cap_clear();

        #3;
        check("rst_w", 64'(w), 64'd0);
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_w_stuff", 64'(w_stuff), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(negedge clock);
        rst = 1'b0;
        @(posedge clock);
        #1;
        check("rst_din_ready", 64'(din_ready), 64'd1);

        // Plain word, no stuffing.
        cap_clear();
        send(8'hA5, 1'b0, waited);
        drain();
        check("a5_len", 64'(cap_n), 64'd8);
        check("a5_bits", cap_bits, 64'hA5);
        check("a5_stuff", cap_stuff, 64'h0);

        // All ones.
        cap_clear();
        send(8'hFF, 1'b0, waited);
        drain();
        check("ff_len", 64'(cap_n), 64'd10);
        check("ff_bits", cap_bits, 64'(10'b1110111011));
        check("ff_stuff", cap_stuff, 64'(10'b0001000100));

        // Word ending in a stuff bit.
        cap_clear();
        send(8'h1F, 1'b0, waited);
        drain();
        check("1f_len", 64'(cap_n), 64'd11);
        check("1f_bits", cap_bits, 64'(11'b00011101110));
        check("1f_stuff", cap_stuff, 64'(11'b00010010001));

        // Back-to-back with din_valid held high.
        cap_clear();
        hs_cnt = 0;
        send(8'h00, 1'b1, waited);
        send(8'hFF, 1'b0, waited);
        drain();
        check("b2b_len", 64'(cap_n), 64'd20);
        check("b2b_bits", cap_bits, 64'(20'b0001000100_1110111011));
        check("b2b_stuff", cap_stuff, 64'(20'b0001000100_0001000100));
        check("b2b_handshakes", 64'(hs_cnt), 64'd2);

        // Backpressure: request raised mid-word waits for the last bit.
        cap_clear();
        send(8'hA5, 1'b0, waited);
        repeat (3) step();
        send(8'h3C, 1'b0, waited);
        check("bp_wait", 64'(waited), 64'd5);
        drain();
        check("bp_len", 64'(cap_n), 64'd17);

        // Asynchronous reset in the middle of a word.
        cap_clear();
        send(8'hF0, 1'b0, waited);
        begin
            int n;
            n = 0;
            while (cap_n < 5 && n < 20) begin
                step();
                n = n + 1;
            end
        end
        check("arst_reached", 64'(cap_n), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_w_valid", 64'(w_valid), 64'd0);
        check("arst_w", 64'(w), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_w_stuff", 64'(w_stuff), 64'd0);
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        exp_q.delete();
        m_run   = 0;
        m_last  = 1'b0;
        obs_run = 0;
        @(posedge clock);
        #1;
        check("arst_din_ready", 64'(din_ready), 64'd1);
        cap_clear();
        send(8'hA5, 1'b0, waited);
        drain();
        check("arst_a5_len", 64'(cap_n), 64'd8);
        check("arst_a5_bits", cap_bits, 64'hA5);
        check("arst_a5_stuff", cap_stuff, 64'h0);

        // Random words with random idle gaps, including zero-gap back-to-back.
        for (int k = 0; k < 80; k++) begin
            int gap;
            logic [DATA_W-1:0] d;
            gap = $urandom_range(0, 3);
            d   = DATA_W'($urandom);
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? '0 : '1;
            for (int g = 0; g < gap; g++) step();
            send(d, 1'b0, waited);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
